// File: rtl/ask4_sym_slicer_pkg.sv
// Shared constants and saturation helpers for the 4-ASK symbol slicer.
// Samples are signed 1s17 (18 bits); decision codes run from -3a (00) to +3a (11).
package ask4_sym_slicer_pkg;

  localparam int SAMPLE_W = 18;

  localparam logic [1:0] ASK_M3 = 2'b00;
  localparam logic [1:0] ASK_M1 = 2'b01;
  localparam logic [1:0] ASK_P1 = 2'b10;
  localparam logic [1:0] ASK_P3 = 2'b11;

  localparam logic signed [17:0] REF_INIT_DEF = 18'sd32768;

  localparam logic [0:0] ST_ACQ   = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  function automatic logic signed [17:0] sat18(input logic signed [19:0] v);
    if (v > 20'sd131071) begin
      return 18'sd131071;
    end else if (v < -20'sd131072) begin
      return 18'sh20000;
    end else begin
      return v[17:0];
    end
  endfunction

  // |v| in 18 bits; the single unrepresentable magnitude clips to full scale
  function automatic logic [17:0] abs_sat18(input logic signed [17:0] v);
    if (v == 18'sh20000) begin
      return 18'd131071;
    end else if (v < 18'sd0) begin
      return 18'(-v);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/ask4_sym_slicer_decision.sv
// Combinational 4-ASK slicer: thresholds at 0 and +/-R, levels +/-R/2 and +/-3R/2.
// Ties resolve toward the positive/outer code; the error is saturated to 18 bits.
module ask4_sym_slicer_decision
  import ask4_sym_slicer_pkg::*;
(
  input  logic signed [17:0] i_x,
  input  logic signed [17:0] i_ref,
  output logic [1:0]         o_code,
  output logic signed [18:0] o_level,
  output logic signed [17:0] o_err
);

  logic signed [18:0] w_x;
  logic signed [18:0] w_r;
  logic signed [18:0] w_half;
  logic signed [18:0] w_three;
  logic signed [18:0] w_neg_r;
  logic signed [19:0] w_diff;

  assign w_x     = {i_x[17], i_x};
  assign w_r     = {i_ref[17], i_ref};
  assign w_half  = w_r >>> 1;
  assign w_three = w_r + w_half;
  assign w_neg_r = -w_r;

  // Region select against the three thresholds
  always_comb begin
    o_code  = ASK_M3;
    o_level = -w_three;
    if (w_x >= w_r) begin
      o_code  = ASK_P3;
      o_level = w_three;
    end else if (w_x >= 19'sd0) begin
      o_code  = ASK_P1;
      o_level = w_half;
    end else if (w_x >= w_neg_r) begin
      o_code  = ASK_M1;
      o_level = -w_half;
    end else begin
      o_code  = ASK_M3;
      o_level = -w_three;
    end
  end

  assign w_diff = {w_x[18], w_x} - {o_level[18], o_level};
  assign o_err  = sat18(w_diff);

endmodule

// File: rtl/ask4_sym_slicer.sv
// Symbol-rate capture, 4-ASK decision and block-averaged reference/error-power tracking.
// Latency from the sym_clk_en edge to sym_out is two clocks.
module ask4_sym_slicer
  import ask4_sym_slicer_pkg::*;
#(
  parameter int               AVG_LOG2 = 8,
  parameter logic signed [17:0] REF_INIT = 18'sd32768
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_sam_clk_en,
  input  logic               i_sym_clk_en,
  input  logic signed [17:0] i_in,
  output logic [1:0]         o_sym_out,
  output logic               o_sym_valid,
  output logic signed [17:0] o_err_out,
  output logic signed [17:0] o_ref_level,
  output logic               o_ref_valid,
  output logic [17:0]        o_err_pow,
  output logic               o_blk_done
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_LAST = {AVG_LOG2{1'b1}};

  logic signed [17:0]  r_sym;
  logic                r_cap_vld;
  logic [0:0]          r_state;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [ACC_W-1:0]    r_abs_acc;
  logic [ACC_W-1:0]    r_pow_acc;
  logic                r_blk_end;
  logic [1:0]          r_sym_out;
  logic                r_sym_valid;
  logic signed [17:0]  r_err_out;
  logic signed [17:0]  r_ref_level;
  logic                r_ref_valid;
  logic [17:0]         r_err_pow;
  logic                r_blk_done;

  logic signed [17:0]  w_ref;
  logic [1:0]          w_code;
  logic signed [18:0]  w_level;
  logic signed [17:0]  w_err;
  logic signed [35:0]  w_sq;
  logic [17:0]         w_abs;
  logic [ACC_W-1:0]    w_abs_next;
  logic [ACC_W-1:0]    w_pow_next;
  logic                w_unused_ok;

  assign w_ref = (r_state == ST_ACQ) ? REF_INIT : r_ref_level;

  ask4_sym_slicer_decision u_decision (
    .i_x     (r_sym),
    .i_ref   (w_ref),
    .o_code  (w_code),
    .o_level (w_level),
    .o_err   (w_err)
  );

  assign w_sq  = w_err * w_err;
  assign w_abs = abs_sat18(r_sym);

  // A symbol landing on the block-end cycle seeds the next block's accumulators
  always_comb begin
    w_abs_next = r_blk_end ? {ACC_W{1'b0}} : r_abs_acc;
    w_pow_next = r_blk_end ? {ACC_W{1'b0}} : r_pow_acc;
    if (r_cap_vld) begin
      w_abs_next = w_abs_next + {{AVG_LOG2{1'b0}}, w_abs};
      w_pow_next = w_pow_next + {{AVG_LOG2{1'b0}}, w_sq[34:17]};
    end else begin
      w_abs_next = w_abs_next;
      w_pow_next = w_pow_next;
    end
  end

  assign w_unused_ok = &{1'b0, i_sam_clk_en, w_sq[35], w_sq[16:0], w_level};

  // Capture, slice, accumulate and block-end update
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sym       <= 18'sd0;
      r_cap_vld   <= 1'b0;
      r_state     <= ST_ACQ;
      r_cnt       <= {AVG_LOG2{1'b0}};
      r_abs_acc   <= {ACC_W{1'b0}};
      r_pow_acc   <= {ACC_W{1'b0}};
      r_blk_end   <= 1'b0;
      r_sym_out   <= 2'b00;
      r_sym_valid <= 1'b0;
      r_err_out   <= 18'sd0;
      r_ref_level <= REF_INIT;
      r_ref_valid <= 1'b0;
      r_err_pow   <= 18'd0;
      r_blk_done  <= 1'b0;
    end else begin
      if (i_sym_clk_en) begin
        r_sym <= i_in;
      end
      r_cap_vld   <= i_sym_clk_en;
      r_sym_valid <= r_cap_vld;
      if (r_cap_vld) begin
        r_sym_out <= w_code;
        r_err_out <= w_err;
        r_cnt     <= r_cnt + AVG_LOG2'(1);
      end
      r_blk_end  <= r_cap_vld && (r_cnt == CNT_LAST);
      r_abs_acc  <= w_abs_next;
      r_pow_acc  <= w_pow_next;
      r_blk_done <= r_blk_end;
      if (r_blk_end) begin
        r_ref_level <= $signed(r_abs_acc[AVG_LOG2 +: 18]);
        r_err_pow   <= r_pow_acc[AVG_LOG2 +: 18];
        r_state     <= ST_TRACK;
        r_ref_valid <= 1'b1;
      end
    end
  end

  assign o_sym_out   = r_sym_out;
  assign o_sym_valid = r_sym_valid;
  assign o_err_out   = r_err_out;
  assign o_ref_level = r_ref_level;
  assign o_ref_valid = r_ref_valid;
  assign o_err_pow   = r_err_pow;
  assign o_blk_done  = r_blk_done;

endmodule

// File: tb/tb_ask4_sym_slicer.sv
// Directed, table-driven bench for ask4_sym_slicer (AVG_LOG2=8, REF_INIT=32768).
module tb_ask4_sym_slicer;

  typedef struct {
    logic signed [17:0] x;
    logic [1:0]         code;
    logic signed [17:0] err;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               sam_en;
  logic               sym_en;
  logic signed [17:0] in_x;
  logic [1:0]         sym_out;
  logic               sym_valid;
  logic signed [17:0] err_out;
  logic signed [17:0] ref_level;
  logic               ref_valid;
  logic [17:0]        err_pow;
  logic               blk_done;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t thr_tab[14];
  vec_t pat[4];

  always #5 clk = ~clk;

  ask4_sym_slicer #(.AVG_LOG2(8), .REF_INIT(18'sd32768)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_sam_clk_en (sam_en),
    .i_sym_clk_en (sym_en),
    .i_in         (in_x),
    .o_sym_out    (sym_out),
    .o_sym_valid  (sym_valid),
    .o_err_out    (err_out),
    .o_ref_level  (ref_level),
    .o_ref_valid  (ref_valid),
    .o_err_pow    (err_pow),
    .o_blk_done   (blk_done)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sym_valid"}, sym_valid, 0);
    chk({tag, "_sym_out"},   sym_out,   0);
    chk({tag, "_err_out"},   err_out,   0);
    chk({tag, "_ref_level"}, ref_level, 32768);
    chk({tag, "_ref_valid"}, ref_valid, 0);
    chk({tag, "_err_pow"},   err_pow,   0);
    chk({tag, "_blk_done"},  blk_done,  0);
  endtask

  // One isolated symbol: enable for one clock, outputs checked two edges later
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    in_x   = v.x;
    sym_en = 1'b1;
    @(posedge clk);
    #1;
    sym_en = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, sym_valid, 1);
    chk({tag, "_code"},  sym_out,   v.code);
    chk({tag, "_err"},   err_out,   v.err);
    chk({tag, "_nodone"}, blk_done, 0);
  endtask

  task automatic run_block(input string tag, input int exp_ref, input int exp_pow);
    for (int i = 0; i < 256; i++) begin
      apply(pat[i % 4], tag);
    end
    @(posedge clk);
    #1;
    chk({tag, "_blk_done"},  blk_done,  1);
    chk({tag, "_ref_level"}, ref_level, exp_ref);
    chk({tag, "_err_pow"},   err_pow,   exp_pow);
    chk({tag, "_ref_valid"}, ref_valid, 1);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, blk_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int blk_cyc;
    vec_t v;

    reset  = 1'b1;
    sam_en = 1'b0;
    sym_en = 1'b0;
    in_x   = 18'sd0;

    thr_tab[0]  = '{18'sd32768,   2'b11, -18'sd16384};
    thr_tab[1]  = '{18'sd32767,   2'b10,  18'sd16383};
    thr_tab[2]  = '{18'sd0,       2'b10, -18'sd16384};
    thr_tab[3]  = '{-18'sd1,      2'b01,  18'sd16383};
    thr_tab[4]  = '{-18'sd32768,  2'b01, -18'sd16384};
    thr_tab[5]  = '{-18'sd32769,  2'b00,  18'sd16383};
    thr_tab[6]  = '{-18'sd49152,  2'b00,  18'sd0};
    thr_tab[7]  = '{-18'sd16384,  2'b01,  18'sd0};
    thr_tab[8]  = '{18'sd16384,   2'b10,  18'sd0};
    thr_tab[9]  = '{18'sd49152,   2'b11,  18'sd0};
    thr_tab[10] = '{18'sd17408,   2'b10,  18'sd1024};
    thr_tab[11] = '{-18'sd15360,  2'b01,  18'sd1024};
    thr_tab[12] = '{18'sh20000,   2'b00, -18'sd81920};
    thr_tab[13] = '{18'sd131071,  2'b11,  18'sd81919};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst0");
    @(negedge clk);
    reset = 1'b0;

    // Thresholds in ACQ (slicing with REF_INIT), then pad to 100 symbols
    for (int i = 0; i < 14; i++) begin
      apply(thr_tab[i], $sformatf("thr%0d", i));
    end
    v = '{18'sd16384, 2'b10, 18'sd0};
    for (int i = 14; i < 100; i++) begin
      apply(v, "pad");
    end

    // Mid-block reset with an enable present: reset must win
    @(negedge clk);
    reset  = 1'b1;
    sym_en = 1'b1;
    in_x   = 18'sd49152;
    @(posedge clk);
    #1;
    chk_reset_state("rst_mid");
    @(negedge clk);
    reset  = 1'b0;
    sym_en = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_nocap", sym_valid, 0);
    chk("rst_mid_acq", ref_valid, 0);

    pat[0] = '{-18'sd49152, 2'b00, 18'sd0};
    pat[1] = '{-18'sd16384, 2'b01, 18'sd0};
    pat[2] = '{18'sd16384,  2'b10, 18'sd0};
    pat[3] = '{18'sd49152,  2'b11, 18'sd0};
    run_block("ideal", 32768, 0);

    pat[0] = '{-18'sd48128, 2'b00, 18'sd1024};
    pat[1] = '{-18'sd15360, 2'b01, 18'sd1024};
    pat[2] = '{18'sd17408,  2'b10, 18'sd1024};
    pat[3] = '{18'sd50176,  2'b11, 18'sd1024};
    run_block("noise", 32768, 8);

    pat[0] = '{-18'sd98304, 2'b00, -18'sd49152};
    pat[1] = '{-18'sd32768, 2'b01, -18'sd16384};
    pat[2] = '{18'sd32768,  2'b11, -18'sd16384};
    pat[3] = '{18'sd98304,  2'b11,  18'sd49152};
    run_block("gain", 65536, 10240);

    pat[0] = '{-18'sd98304, 2'b00, 18'sd0};
    pat[1] = '{-18'sd32768, 2'b01, 18'sd0};
    pat[2] = '{18'sd32768,  2'b10, 18'sd0};
    pat[3] = '{18'sd98304,  2'b11, 18'sd0};
    run_block("x2", 65536, 0);

    // Back-to-back full-scale negative input; first enable edge is edge 0
    @(negedge clk);
    in_x    = 18'sh20000;
    sym_en  = 1'b1;
    blk_cyc = -1;
    @(posedge clk);
    #1;
    chk("b2b_valid0", sym_valid, 0);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (cyc == 256) begin
        sym_en = 1'b0;
      end
      @(posedge clk);
      #1;
      if (cyc <= 256) begin
        chk("b2b_valid", sym_valid, 1);
        chk("b2b_code", sym_out, 0);
        chk("b2b_err", err_out, -32768);
      end
      if (blk_done == 1'b1) begin
        blk_cyc = cyc;
        break;
      end
    end
    chk("b2b_done_cyc", blk_cyc, 257);
    chk("b2b_ref_level", ref_level, 131071);
    chk("b2b_err_pow", err_pow, 8192);

    apply('{18'sh20000, 2'b00, 18'sd65534}, "fullref");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
